// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the animated sprite store.
//   anim_mode_t : sequencer modes (LOOP, PINGPONG, ONESHOT, FREEZE)
//   DEF_*       : default pixel depth and sprite geometry
//   frame_size  : pixels per stored frame
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [1:0] {
    LOOP     = 2'd0,
    PINGPONG = 2'd1,
    ONESHOT  = 2'd2,
    FREEZE   = 2'd3
  } anim_mode_t;

  localparam int DEF_PIX_W = 4;
  localparam int DEF_SPR_W = 20;
  localparam int DEF_SPR_H = 40;

  function automatic int frame_size(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/sprite_frame_seq.sv
// -----------------------------------------------------------------------------
// sprite_frame_seq
// Animation sequencer: counts frame_ticks and steps the current frame
// according to the selected mode.
// Ports:
//   CLK, Reset    clock, asynchronous active-high reset
//   frame_tick    one pulse per video frame
//   anim_en       advance enable
//   anim_mode     LOOP / PINGPONG / ONESHOT / FREEZE
//   hold          frame_ticks per animation frame (0 behaves as 1)
//   anim_restart  synchronous restart to frame 0
//   cur_frame     current animation frame
//   anim_done     sticky, ONESHOT has reached the last frame
// -----------------------------------------------------------------------------
module sprite_frame_seq
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 3,
  parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               anim_en,
  input  logic [1:0]         anim_mode,
  input  logic [7:0]         hold,
  input  logic               anim_restart,
  output logic [FRAME_W-1:0] cur_frame,
  output logic               anim_done
);

  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);

  logic [7:0]         count_reg, count_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic               dir_down_reg, dir_down_next;
  logic               done_reg, done_next;

  anim_mode_t mode;
  logic [7:0] last_count;
  logic       step_en;

  assign mode       = anim_mode_t'(anim_mode);
  assign last_count = (hold == 8'd0) ? 8'd0 : hold - 8'd1;
  assign step_en    = frame_tick && anim_en && (mode != FREEZE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_reg    <= 8'd0;
      frame_reg    <= '0;
      dir_down_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      count_reg    <= count_next;
      frame_reg    <= frame_next;
      dir_down_reg <= dir_down_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    count_next    = count_reg;
    frame_next    = frame_reg;
    dir_down_next = dir_down_reg;
    done_next     = done_reg;
    if (anim_restart) begin
      count_next    = 8'd0;
      frame_next    = '0;
      dir_down_next = 1'b0;
      done_next     = 1'b0;
    end else if (step_en) begin
      // >= rather than == so a hold value lowered mid-count advances at once
      // instead of wrapping the counter through 255.
      if (count_reg >= last_count) begin
        count_next = 8'd0;
        case (mode)
          LOOP: begin
            frame_next = (frame_reg == LAST) ? '0 : frame_reg + FRAME_W'(1);
          end
          PINGPONG: begin
            if (NUM_FRAMES > 1) begin
              // Climb while heading up and below the top, or when sitting at
              // frame 0 heading down; otherwise descend.
              if (dir_down_reg ? (frame_reg == '0) : (frame_reg != LAST)) begin
                frame_next    = frame_reg + FRAME_W'(1);
                dir_down_next = 1'b0;
              end else begin
                frame_next    = frame_reg - FRAME_W'(1);
                dir_down_next = 1'b1;
              end
            end
          end
          ONESHOT: begin
            if (frame_reg == LAST) begin
              done_next = 1'b1;
            end else begin
              frame_next = frame_reg + FRAME_W'(1);
              if (frame_reg + FRAME_W'(1) == LAST) begin
                done_next = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end else begin
        count_next = count_reg + 8'd1;
      end
    end
  end

  assign cur_frame = frame_reg;
  assign anim_done = done_reg;

endmodule

// File: rtl/sprite_anim_ram.sv
// -----------------------------------------------------------------------------
// sprite_anim_ram
// Multi-frame palette-indexed sprite store with a 2-cycle pixel read pipeline
// and a built-in animation sequencer selecting the frame being read.
// Ports:
//   CLK, Reset            clock, asynchronous active-high reset
//   we/wr_addr/wr_data    flat-address pixel write (out-of-range ignored)
//   rd_req/rel_x/rel_y    sprite-relative pixel request
//   frame_tick, anim_en, anim_mode, hold, anim_restart  sequencer controls
//   pixel_idx             palette index, 0 when not valid
//   pixel_valid           response to an in-range request
//   opaque                pixel_valid and pixel_idx != TRANSP_IDX
//   cur_frame, anim_done  sequencer state
// -----------------------------------------------------------------------------
module sprite_anim_ram
  import sprite_pkg::*;
#(
  parameter int    PIX_W      = DEF_PIX_W,
  parameter int    SPR_W      = DEF_SPR_W,
  parameter int    SPR_H      = DEF_SPR_H,
  parameter int    NUM_FRAMES = 3,
  parameter int    TRANSP_IDX = 0,
  parameter string INIT_FILE  = "",
  localparam int   FRAME_SIZE = frame_size(SPR_W, SPR_H),
  localparam int   DEPTH      = NUM_FRAMES * FRAME_SIZE,
  localparam int   ADDR_W     = $clog2(DEPTH),
  localparam int   FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               rd_req,
  input  logic [9:0]         rel_x,
  input  logic [9:0]         rel_y,
  input  logic               frame_tick,
  input  logic               anim_en,
  input  logic [1:0]         anim_mode,
  input  logic [7:0]         hold,
  input  logic               anim_restart,
  output logic [PIX_W-1:0]   pixel_idx,
  output logic               pixel_valid,
  output logic               opaque,
  output logic [FRAME_W-1:0] cur_frame,
  output logic               anim_done
);

  logic [PIX_W-1:0] mem [DEPTH];

  sprite_frame_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_W    (FRAME_W)
  ) u_seq (
    .CLK          (CLK),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .anim_en      (anim_en),
    .anim_mode    (anim_mode),
    .hold         (hold),
    .anim_restart (anim_restart),
    .cur_frame    (cur_frame),
    .anim_done    (anim_done)
  );

  logic              in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ok;

  assign in_range = rd_req && (32'(rel_x) < SPR_W) && (32'(rel_y) < SPR_H);

  // Out-of-range requests read address 0 so the array is never indexed past
  // its end; their data is masked at the output anyway.
  assign rd_addr = in_range ? (ADDR_W'(cur_frame) * ADDR_W'(FRAME_SIZE)
                               + ADDR_W'(rel_y) * ADDR_W'(SPR_W)
                               + ADDR_W'(rel_x))
                            : '0;

  assign wr_ok = we && (32'(wr_addr) < DEPTH);

  // Block RAM with registered read plus an output register. The array read
  // happens on the request's own sampling edge, so a write on that same edge
  // is not yet visible (read-first), and cur_frame is captured with the
  // request: a frame change on that edge does not affect it.
  logic [PIX_W-1:0] data1_reg, data2_reg;

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    data1_reg <= mem[rd_addr];
    data2_reg <= data1_reg;
  end

  logic valid1_reg, valid2_reg;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      valid1_reg <= 1'b0;
      valid2_reg <= 1'b0;
    end else begin
      valid1_reg <= in_range;
      valid2_reg <= valid1_reg;
    end
  end

  // Data registers are not reset; gating with the reset-cleared valid makes
  // every output read as 0 the moment Reset rises.
  assign pixel_valid = valid2_reg;
  assign pixel_idx   = valid2_reg ? data2_reg : '0;
  assign opaque      = valid2_reg && (data2_reg != PIX_W'(TRANSP_IDX));

endmodule

// File: tb/tb_sprite_anim_ram.sv
module tb_sprite_anim_ram;
  import sprite_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        we;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic        rd_req;
  logic [9:0]  rel_x, rel_y;
  logic        frame_tick, anim_en, anim_restart;
  logic [1:0]  anim_mode;
  logic [7:0]  hold;
  logic [3:0]  pixel_idx;
  logic        pixel_valid, opaque;
  logic [1:0]  cur_frame;
  logic        anim_done;

  always #5 CLK = ~CLK;

  sprite_anim_ram dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .we           (we),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rel_x        (rel_x),
    .rel_y        (rel_y),
    .frame_tick   (frame_tick),
    .anim_en      (anim_en),
    .anim_mode    (anim_mode),
    .hold         (hold),
    .anim_restart (anim_restart),
    .pixel_idx    (pixel_idx),
    .pixel_valid  (pixel_valid),
    .opaque       (opaque),
    .cur_frame    (cur_frame),
    .anim_done    (anim_done)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] idx;
    logic       op;
  } pix_exp_t;

  typedef struct packed {
    logic [1:0] f;
    logic       d;
  } seq_exp_t;

  pix_exp_t exp_q[$];
  seq_exp_t seq_q[$];

  int checks = 0;
  int errors = 0;
  int n_pix  = 0;
  int n_seq  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Bench-side view of which edges carry a response or a sequencer update.
  logic req_d1, req_d2, tick_d;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      req_d1 <= 1'b0;
      req_d2 <= 1'b0;
      tick_d <= 1'b0;
    end else begin
      req_d1 <= rd_req;
      req_d2 <= req_d1;
      tick_d <= frame_tick | anim_restart;
    end
  end

  // Requests in flight when Reset hits are dropped by the design.
  always @(posedge Reset) exp_q.delete();

  always @(negedge CLK) begin
    if (!Reset) begin
      if (req_d2) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_underflow: got response, expected none queued");
        end else begin
          pix_exp_t e;
          e = exp_q.pop_front();
          n_pix++;
          $display("pix #%0d: valid=%0b idx=%0h opaque=%0b (exp %0b/%0h/%0b)",
                   n_pix, pixel_valid, pixel_idx, opaque, e.v, e.idx, e.op);
          chk("pix_response", {26'd0, pixel_valid, pixel_idx, opaque}, {26'd0, e});
        end
      end else begin
        chk("spurious_valid", {31'd0, pixel_valid}, 32'd0);
      end
      if (tick_d) begin
        if (seq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL seq_underflow: got update, expected none queued");
        end else begin
          seq_exp_t s;
          s = seq_q.pop_front();
          n_seq++;
          $display("seq #%0d: cur_frame=%0d anim_done=%0b (exp %0d/%0b)",
                   n_seq, cur_frame, anim_done, s.f, s.d);
          chk("seq_state", {29'd0, cur_frame, anim_done}, {29'd0, s});
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int addr, input logic [3:0] data);
    we = 1'b1;
    wr_addr = 12'(addr);
    wr_data = data;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input logic v, input logic [3:0] idx);
    pix_exp_t e;
    rd_req = 1'b1;
    rel_x = 10'(x);
    rel_y = 10'(y);
    e.v = v;
    e.idx = idx;
    e.op = v && (idx != 4'd0);
    exp_q.push_back(e);
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_tick(input logic t, input logic r, input int f, input logic d);
    seq_exp_t s;
    s.f = 2'(f);
    s.d = d;
    seq_q.push_back(s);
    frame_tick = t;
    anim_restart = r;
    step();
    frame_tick = 1'b0;
    anim_restart = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int loop_exp[12];
    int pp_exp[6];
    loop_exp = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};
    pp_exp   = '{1, 2, 1, 0, 1, 2};

    Reset = 1'b0;
    we = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rel_x = '0; rel_y = '0;
    frame_tick = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
    anim_mode = LOOP; hold = 8'd1;
    #1 Reset = 1'b1;
    #2;
    chk("rst_pixel_idx", {28'd0, pixel_idx}, 32'd0);
    chk("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    chk("rst_opaque", {31'd0, opaque}, 32'd0);
    chk("rst_cur_frame", {30'd0, cur_frame}, 32'd0);
    chk("rst_anim_done", {31'd0, anim_done}, 32'd0);
    step();
    step();
    Reset = 1'b0;

    // Memory image: frame1 (3,1)=5, frame0 (0,0)=0, frame0 (19,39)=A,
    // frame2 (3,1)=9, frame0 (10,2)=3.
    wr(823, 4'h5);
    wr(0, 4'h0);
    wr(799, 4'hA);
    wr(1623, 4'h9);
    wr(50, 4'h3);

    // Frame 0 reads, including the coordinate boundaries.
    rd(19, 39, 1'b1, 4'hA);
    rd(0, 0, 1'b1, 4'h0);
    rd(20, 0, 1'b0, 4'h0);
    rd(0, 40, 1'b0, 4'h0);
    rd(1023, 1023, 1'b0, 4'h0);

    // Move to frame 1 and read the written pixel.
    anim_en = 1'b1;
    anim_mode = LOOP;
    hold = 8'd1;
    do_tick(1'b1, 1'b0, 1, 1'b0);
    rd(3, 1, 1'b1, 4'h5);

    // Request sampled on the edge that moves to frame 2 still reads frame 1.
    begin
      seq_exp_t s;
      s.f = 2'd2;
      s.d = 1'b0;
      seq_q.push_back(s);
      frame_tick = 1'b1;
      rd(3, 1, 1'b1, 4'h5);
      frame_tick = 1'b0;
    end
    rd(3, 1, 1'b1, 4'h9);
    step();

    do_tick(1'b0, 1'b1, 0, 1'b0);

    // LOOP, hold=2.
    hold = 8'd2;
    for (int i = 0; i < 12; i++) do_tick(1'b1, 1'b0, loop_exp[i], 1'b0);

    // hold=0 acts as hold=1.
    hold = 8'd0;
    do_tick(1'b1, 1'b0, 1, 1'b0);
    do_tick(1'b1, 1'b0, 2, 1'b0);
    do_tick(1'b1, 1'b0, 0, 1'b0);

    // PINGPONG, hold=1.
    do_tick(1'b0, 1'b1, 0, 1'b0);
    anim_mode = PINGPONG;
    hold = 8'd1;
    for (int i = 0; i < 6; i++) do_tick(1'b1, 1'b0, pp_exp[i], 1'b0);

    // FREEZE and anim_en=0 hold the frame; PINGPONG at the top then reverses.
    anim_mode = FREEZE;
    do_tick(1'b1, 1'b0, 2, 1'b0);
    anim_mode = LOOP;
    anim_en = 1'b0;
    do_tick(1'b1, 1'b0, 2, 1'b0);
    anim_en = 1'b1;
    anim_mode = PINGPONG;
    do_tick(1'b1, 1'b0, 1, 1'b0);

    // ONESHOT.
    do_tick(1'b0, 1'b1, 0, 1'b0);
    anim_mode = ONESHOT;
    do_tick(1'b1, 1'b0, 1, 1'b0);
    do_tick(1'b1, 1'b0, 2, 1'b1);
    do_tick(1'b1, 1'b0, 2, 1'b1);
    do_tick(1'b1, 1'b0, 2, 1'b1);
    // Restart wins over a simultaneous tick.
    do_tick(1'b1, 1'b1, 0, 1'b0);

    // Same-address write and read in one cycle: old data, then new data.
    begin
      pix_exp_t e;
      e.v = 1'b1;
      e.idx = 4'h3;
      e.op = 1'b1;
      exp_q.push_back(e);
      we = 1'b1; wr_addr = 12'd50; wr_data = 4'hC;
      rd_req = 1'b1; rel_x = 10'd10; rel_y = 10'd2;
      step();
      we = 1'b0;
      rd_req = 1'b0;
    end
    rd(10, 2, 1'b1, 4'hC);
    step();

    // Asynchronous reset with requests in flight.
    anim_mode = LOOP;
    do_tick(1'b1, 1'b0, 1, 1'b0);
    rd(3, 1, 1'b1, 4'h5);
    rd(3, 1, 1'b1, 4'h5);
    rd(3, 1, 1'b1, 4'h5);
    chk("pre_rst_valid", {31'd0, pixel_valid}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_pixel_idx", {28'd0, pixel_idx}, 32'd0);
    chk("mid_rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    chk("mid_rst_opaque", {31'd0, opaque}, 32'd0);
    chk("mid_rst_cur_frame", {30'd0, cur_frame}, 32'd0);
    step();
    step();
    Reset = 1'b0;
    repeat (5) step();
    chk("post_rst_cur_frame", {30'd0, cur_frame}, 32'd0);

    repeat (4) step();
    chk("pix_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("seq_queue_empty", 32'(seq_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
